// File: rtl/led_receiver.sv
// led_receiver: decodes a WS2812B strand into one GRB word per LED,
// with frames delimited by long low gaps on the line.
module led_receiver #(
   parameter int CLOCK_SPEED = 100_000_000,
   parameter int NUM_LEDS    = 20
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        strand_in,
   output logic [7:0]                  green_out,
   output logic [7:0]                  red_out,
   output logic [7:0]                  blue_out,
   output logic [$clog2(NUM_LEDS)-1:0] led_index_out,
   output logic                        color_valid,
   output logic                        frame_end,
   output logic                        error_out
);

   localparam longint CS      = longint'(CLOCK_SPEED);
   localparam int     RES_CYC = int'((50_000 * CS) / 1_000_000_000);
   localparam int     T_THR   = int'((600 * CS) / 1_000_000_000);
   localparam int     T_MIN   = int'((150 * CS) / 1_000_000_000);
   localparam int     T_MAX   = int'((1_100 * CS) / 1_000_000_000);
   localparam int     CW      = $clog2(RES_CYC + 1);
   localparam int     IW      = $clog2(NUM_LEDS);

   localparam logic [CW-1:0] C_RES  = CW'(RES_CYC - 1);
   localparam logic [CW-1:0] C_THR  = CW'(T_THR);
   localparam logic [CW-1:0] C_MIN  = CW'(T_MIN);
   localparam logic [CW-1:0] C_MAX  = CW'(T_MAX - 1);
   localparam logic [IW-1:0] C_LAST = IW'(NUM_LEDS - 1);

   typedef enum logic [2:0] {
      S_WAIT = 3'd0,
      S_IDLE = 3'd1,
      S_HIGH = 3'd2,
      S_LOW  = 3'd3,
      S_DISC = 3'd4
   } state_t;

   state_t        r_state;
   logic          r_meta;
   logic          r_sync;
   logic          r_prev;
   logic [CW-1:0] r_cnt;
   logic [4:0]    r_bits;
   logic [23:0]   r_buf;
   logic [IW-1:0] r_idx;
   logic          r_full;
   logic [7:0]    r_green;
   logic [7:0]    r_red;
   logic [7:0]    r_blue;
   logic          r_valid;
   logic          r_fend;
   logic          r_err;

   logic          w_rise;
   logic          w_fall;
   logic          w_bit;
   logic [23:0]   w_word;

   assign w_rise = r_sync & ~r_prev;
   assign w_fall = ~r_sync & r_prev;
   assign w_bit  = (r_cnt >= C_THR);
   assign w_word = {r_buf[22:0], w_bit};

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_prev  <= 1'b0;
         r_state <= S_WAIT;
         r_cnt   <= '0;
         r_bits  <= '0;
         r_buf   <= '0;
         r_idx   <= '0;
         r_full  <= 1'b0;
         r_green <= '0;
         r_red   <= '0;
         r_blue  <= '0;
         r_valid <= 1'b0;
         r_fend  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_meta  <= strand_in;
         r_sync  <= r_meta;
         r_prev  <= r_sync;
         r_valid <= 1'b0;
         r_fend  <= 1'b0;
         r_err   <= 1'b0;

         // index advances after the pulse; the last slot saturates
         if (r_valid) begin
            if (r_idx == C_LAST) begin
               r_full <= 1'b1;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end

         unique case (r_state)
            S_WAIT: begin
               if (r_sync) begin
                  r_cnt <= '0;
               end else if (r_cnt == C_RES) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_IDLE: begin
               if (w_rise) begin
                  r_cnt   <= '0;
                  r_state <= S_HIGH;
               end
            end

            S_HIGH: begin
               if (w_fall) begin
                  r_cnt <= '0;
                  if (r_cnt < C_MIN) begin
                     r_err   <= 1'b1;
                     r_bits  <= '0;
                     r_state <= S_DISC;
                  end else if (r_bits == 5'd23) begin
                     r_bits <= '0;
                     r_buf  <= w_word;
                     if (r_full) begin
                        r_err   <= 1'b1;
                        r_state <= S_DISC;
                     end else begin
                        r_valid <= 1'b1;
                        r_green <= w_word[23:16];
                        r_red   <= w_word[15:8];
                        r_blue  <= w_word[7:0];
                        r_state <= S_LOW;
                     end
                  end else begin
                     r_bits  <= r_bits + 5'd1;
                     r_buf   <= w_word;
                     r_state <= S_LOW;
                  end
               end else if (r_cnt == C_MAX) begin
                  r_err   <= 1'b1;
                  r_bits  <= '0;
                  r_cnt   <= '0;
                  r_state <= S_DISC;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_LOW: begin
               if (w_rise) begin
                  r_cnt   <= '0;
                  r_state <= S_HIGH;
               end else if (r_cnt == C_RES) begin
                  // gap mid-word drops the partial word
                  r_fend  <= 1'b1;
                  r_err   <= (r_bits != 5'd0);
                  r_bits  <= '0;
                  r_idx   <= '0;
                  r_full  <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_DISC: begin
               if (r_sync) begin
                  r_cnt <= '0;
               end else if (r_cnt == C_RES) begin
                  r_fend  <= 1'b1;
                  r_bits  <= '0;
                  r_idx   <= '0;
                  r_full  <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            default: begin
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end
         endcase
      end
   end

   assign green_out     = r_green;
   assign red_out       = r_red;
   assign blue_out      = r_blue;
   assign led_index_out = r_idx;
   assign color_valid   = r_valid;
   assign frame_end     = r_fend;
   assign error_out     = r_err;

endmodule

// File: tb/tb_led_receiver.sv
// tb_led_receiver: drives timed WS2812B waveforms and checks decoded
// events against a queue of expected results.
`timescale 1ns/1ps
module tb_led_receiver;

   localparam int CS = 50_000_000;
   localparam int NL = 4;
   localparam int IW = $clog2(NL);

   localparam logic [2:0] K_COL = 3'b100;
   localparam logic [2:0] K_FE  = 3'b010;
   localparam logic [2:0] K_ERR = 3'b001;
   localparam logic [2:0] K_FEE = 3'b011;

   typedef struct packed {
      logic [2:0]    kind;
      logic [23:0]   word;
      logic [IW-1:0] idx;
   } ev_t;

   logic          clk    = 1'b0;
   logic          rst_in = 1'b1;
   logic          strand = 1'b0;
   logic [7:0]    g;
   logic [7:0]    r;
   logic [7:0]    b;
   logic [IW-1:0] idx;
   logic          cv;
   logic          fe;
   logic          er;

   ev_t         sb_q[$];
   int          n_cmp     = 0;
   int          n_bad     = 0;
   int          cyc       = 0;
   int          fall_cyc  = 0;
   time         t_err     = 0;
   time         t_rise    = 0;
   logic [23:0] last_word = '0;

   led_receiver #(
      .CLOCK_SPEED(CS),
      .NUM_LEDS   (NL)
   ) dut (
      .clk_in       (clk),
      .rst_in       (rst_in),
      .strand_in    (strand),
      .green_out    (g),
      .red_out      (r),
      .blue_out     (b),
      .led_index_out(idx),
      .color_valid  (cv),
      .frame_end    (fe),
      .error_out    (er)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      ev_t        e;
      logic [2:0] k;
      if (!rst_in && (cv || fe || er)) begin
         k = {cv, fe, er};
         if (sb_q.size() == 0) begin
            chk("unexpected", 32'(k), 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("kind", 32'(k), 32'(e.kind));
            if (cv) begin
               chk("word", 32'({g, r, b}), 32'(e.word));
               chk("index", 32'(idx), 32'(e.idx));
               chk("latency", 32'(cyc - fall_cyc), 32'd3);
               last_word = {g, r, b};
            end else begin
               chk("hold", 32'({g, r, b}), 32'(last_word));
            end
            if (fe) chk("idx_clr", 32'(idx), 32'd0);
         end
         if (er) t_err = $time;
      end
   end

   task automatic push(input logic [2:0] k, input logic [23:0] w,
                       input int i);
      ev_t e;
      e.kind = k;
      e.word = w;
      e.idx  = IW'(i);
      sb_q.push_back(e);
   endtask

   task automatic send_bit(input logic v);
      strand = 1'b1;
      #(v ? 800 : 400);
      strand   = 1'b0;
      fall_cyc = cyc;
      #(v ? 450 : 850);
   endtask

   task automatic send_bits(input logic [23:0] w, input int n);
      for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
   endtask

   task automatic gap(input int us);
      strand = 1'b0;
      #(us * 1000);
   endtask

   task automatic do_reset;
      rst_in    = 1'b1;
      last_word = '0;
      #200;
      chk("rst_g", 32'(g), 32'd0);
      chk("rst_r", 32'(r), 32'd0);
      chk("rst_b", 32'(b), 32'd0);
      chk("rst_idx", 32'(idx), 32'd0);
      chk("rst_cv", 32'(cv), 32'd0);
      chk("rst_fe", 32'(fe), 32'd0);
      chk("rst_er", 32'(er), 32'd0);
      rst_in = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want summary");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] w;
      @(posedge clk);
      #5;
      do_reset();
      gap(52);

      // single word with mixed bit timing
      push(K_COL, 24'hFF0080, 0);
      send_bits(24'hFF0080, 24);
      push(K_FE, 24'h0, 0);
      gap(52);

      // back-to-back words, then index restarts after the gap
      push(K_COL, 24'h010203, 0);
      push(K_COL, 24'h040506, 1);
      push(K_COL, 24'h070809, 2);
      send_bits(24'h010203, 24);
      send_bits(24'h040506, 24);
      send_bits(24'h070809, 24);
      push(K_FE, 24'h0, 0);
      gap(52);
      push(K_COL, 24'hAABBCC, 0);
      send_bits(24'hAABBCC, 24);
      push(K_FE, 24'h0, 0);
      gap(52);

      // glitch mid-word: rest of frame discarded
      push(K_ERR, 24'h0, 0);
      push(K_FE, 24'h0, 0);
      send_bits(24'h0F0F0F, 10);
      strand = 1'b1;
      #100;
      strand = 1'b0;
      #1150;
      send_bits(24'hFFFFFF, 13);
      gap(52);
      push(K_COL, 24'h123456, 0);
      send_bits(24'h123456, 24);
      push(K_FE, 24'h0, 0);
      gap(52);

      // partial word followed by a gap
      push(K_FEE, 24'h0, 0);
      send_bits(24'hABCDEF, 12);
      gap(60);

      // one word more than the frame holds
      for (int i = 0; i <= NL; i++) begin
         w = 24'(i) * 24'h111111 + 24'h0F1E2D;
         if (i < NL) push(K_COL, w, i);
         else push(K_ERR, 24'h0, 0);
         send_bits(w, 24);
      end
      push(K_FE, 24'h0, 0);
      gap(52);

      // line stuck high
      push(K_ERR, 24'h0, 0);
      t_rise = $time;
      strand = 1'b1;
      #2000;
      strand = 1'b0;
      chk("tmo_win",
          32'((t_err > t_rise + 1000) && (t_err < t_rise + 1400)),
          32'd1);
      push(K_FE, 24'h0, 0);
      gap(52);

      // reset mid-word drops the word silently
      send_bits(24'hC3C3C3, 12);
      do_reset();
      gap(52);
      push(K_COL, 24'h5AA5FF, 0);
      send_bits(24'h5AA5FF, 24);
      push(K_FE, 24'h0, 0);
      gap(52);

      for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(posedge clk);
      chk("drain", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_receiver.md
LED_RECEIVER -- requirements
Module: led_receiver

Interface
REQ-001 SHALL have parameter CLOCK_SPEED, default 100_000_000, clock frequency in Hz; all cycle thresholds below are given in ns and scaled to cycles as ns/1e9*CLOCK_SPEED.
REQ-002 SHALL have parameter NUM_LEDS, default 20, number of 24-bit words accepted per frame; index width is $clog2(NUM_LEDS).
REQ-003 SHALL have port: clk_in  input  1  system clock, one clock domain only.
REQ-004 SHALL have port: rst_in  input  1  reset; it is synchronous and active-high.
REQ-005 SHALL have port: strand_in  input  1  WS2812B serial data line, asynchronous to clk_in.
REQ-006 SHALL have port: green_out  output  8  first decoded byte of the word.
REQ-007 SHALL have port: red_out  output  8  second decoded byte of the word.
REQ-008 SHALL have port: blue_out  output  8  third decoded byte of the word.
REQ-009 SHALL have port: led_index_out  output  $clog2(NUM_LEDS)  position of the word in the frame, 0 = first after a reset gap.
REQ-010 SHALL have port: color_valid  output  1  single-cycle pulse; colour outputs and index are valid in that cycle.
REQ-011 SHALL have port: frame_end  output  1  single-cycle pulse when a reset gap is detected.
REQ-012 SHALL have port: error_out  output  1  single-cycle pulse on any protocol violation.

Function
REQ-013 SHALL pass strand_in through a 2-flop synchronizer; all edge detection and timing uses the synchronized signal (sync), with edges found by comparing sync to its previous value.
REQ-014 SHALL implement states WAIT_RESET, IDLE, HIGH, LOW and DISCARD.
REQ-015 SHALL treat WAIT_RESET as the post-reset state: it ignores edges, counts consecutive low cycles, and goes to IDLE when sync has been low for RESCyc (50000 ns -> 5000 cycles) cycles; any high sample restarts the count.
REQ-016 SHALL in IDLE go to HIGH on a rising edge and clear the high-cycle counter.
REQ-017 SHALL in HIGH count cycles while sync is high; the falling edge classifies the bit as 1 if high count >= TThrCyc (600 ns -> 60) and as 0 otherwise; the bit is shifted MSB-first into a 24-bit buffer; the state goes to LOW.
REQ-018 SHALL flag high count < TMinCyc (150 ns -> 15) at the falling edge as a glitch error.
REQ-019 SHALL flag high count reaching TMaxCyc (1100 ns -> 110) while still high as a timeout error, without waiting for the falling edge.
REQ-020 SHALL in LOW count cycles while sync is low; a rising edge goes to HIGH and starts a new bit.
REQ-021 SHALL treat a low count reaching RESCyc as a reset gap: frame_end pulses, led index and bit counter are cleared, and the state goes to IDLE; if the bit counter is non-zero, error_out also pulses in the same cycle and the partial word is dropped.
REQ-022 SHALL, on the 24th bit, drive {green_out, red_out, blue_out} = buffer and pulse color_valid, with led_index_out unchanged, exactly 1 cycle after the falling edge is seen on sync (3 clk_in cycles after the strand_in edge); the led index increments in the following cycle.
REQ-023 SHALL hold the colour outputs and led_index_out stable between color_valid pulses.
REQ-024 SHALL treat a word completing while the led index equals NUM_LEDS-1 and a word has already been reported at that index as overflow: no color_valid, error_out pulses, and the state goes to DISCARD; the index never wraps.
REQ-025 SHALL on any error pulse error_out for 1 cycle, clear the bit counter, and go to DISCARD.
REQ-026 SHALL in DISCARD ignore bits until a RESCyc low gap is seen, then pulse frame_end and go to IDLE.
REQ-027 SHALL never assert color_valid and error_out in the same cycle.
REQ-028 SHALL require frame_end to pulse at most once per continuous low period.

Reset
REQ-029 SHALL, while rst_in is high at a clock edge, enter WAIT_RESET, clear all counters and the buffer, and drive green_out, red_out, blue_out, led_index_out, color_valid, frame_end and error_out to 0.
REQ-030 SHALL abandon any in-flight word silently (no error pulse) on rst_in asserted mid-word, and emit no color_valid for it.

Verification
REQ-031 SHALL be verified by: rst, 50 us low, then word 0xFF0080 with 400/850 ns and 800/450 ns bit timing -> one color_valid with G=FF, R=00, B=80, index 0.
REQ-032 SHALL be verified by: 3 back-to-back words 0x010203, 0x040506, 0x070809, then 50 us low -> indices 0,1,2 in order, then one frame_end, and the next word reports index 0.
REQ-033 SHALL be verified by: 100 ns high pulse in the middle of a word -> error_out pulse, no color_valid until after the next 50 us gap.
REQ-034 SHALL be verified by: 12 bits then 60 us low -> frame_end and error_out pulse in the same cycle, no color_valid.
REQ-035 SHALL be verified by: NUM_LEDS+1 words in one frame -> NUM_LEDS color_valid pulses, then one error_out.
REQ-036 SHALL be verified by: line held high 2 us -> error_out after 110 high cycles; asserting rst_in mid-word -> all outputs 0 and no pulses.
